// File: rtl/dct_block_sequencer_if.sv
// Handshake and engine-side signal bundle for dct_block_sequencer.
// master is the sequencer's view; slave is the environment's view.
interface dct_block_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic [63:0]      in_row;
  logic             in_valid;
  logic             in_ready;

  logic [63:0]      eng_pixels_0;
  logic [63:0]      eng_pixels_1;
  logic [63:0]      eng_pixels_2;
  logic [63:0]      eng_pixels_3;
  logic [63:0]      eng_pixels_4;
  logic [63:0]      eng_pixels_5;
  logic [63:0]      eng_pixels_6;
  logic [63:0]      eng_pixels_7;
  logic             eng_start;
  logic             eng_done;
  logic [95:0]      eng_dct_0;
  logic [95:0]      eng_dct_1;
  logic [95:0]      eng_dct_2;
  logic [95:0]      eng_dct_3;
  logic [95:0]      eng_dct_4;
  logic [95:0]      eng_dct_5;
  logic [95:0]      eng_dct_6;
  logic [95:0]      eng_dct_7;

  logic [95:0]      out_row;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  logic             busy;
  logic             timeout_err;
  logic [CNT_W-1:0] blocks_done;

  modport master (
    input  in_row, in_valid, eng_done, out_ready,
    input  eng_dct_0, eng_dct_1, eng_dct_2, eng_dct_3,
    input  eng_dct_4, eng_dct_5, eng_dct_6, eng_dct_7,
    output in_ready, eng_start, out_row, out_valid, out_last,
    output eng_pixels_0, eng_pixels_1, eng_pixels_2, eng_pixels_3,
    output eng_pixels_4, eng_pixels_5, eng_pixels_6, eng_pixels_7,
    output busy, timeout_err, blocks_done
  );

  modport slave (
    output in_row, in_valid, eng_done, out_ready,
    output eng_dct_0, eng_dct_1, eng_dct_2, eng_dct_3,
    output eng_dct_4, eng_dct_5, eng_dct_6, eng_dct_7,
    input  in_ready, eng_start, out_row, out_valid, out_last,
    input  eng_pixels_0, eng_pixels_1, eng_pixels_2, eng_pixels_3,
    input  eng_pixels_4, eng_pixels_5, eng_pixels_6, eng_pixels_7,
    input  busy, timeout_err, blocks_done
  );
endinterface

// File: rtl/dct_block_sequencer.sv
// Buffers 8x8 pixel blocks for the 2-D DCT engine, runs it under a watchdog and
// drains the captured coefficient rows; input of the next block overlaps run/drain.
module dct_block_sequencer #(
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned CNT_W   = 16
) (
  input logic                   Clk,
  input logic                   Reset,
  dct_block_sequencer_if.master bus_io
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [3:0]       in_cnt_q, in_cnt_d;
  logic [2:0]       out_idx_q, out_idx_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic             eng_start_q, eng_start_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] blocks_q, blocks_d;
  logic [63:0]      pix_q  [8];
  logic [95:0]      obuf_q [8];
  logic [95:0]      dct_in [8];

  logic in_ready, in_acc, capture, out_valid;

  assign dct_in[0] = bus_io.eng_dct_0;
  assign dct_in[1] = bus_io.eng_dct_1;
  assign dct_in[2] = bus_io.eng_dct_2;
  assign dct_in[3] = bus_io.eng_dct_3;
  assign dct_in[4] = bus_io.eng_dct_4;
  assign dct_in[5] = bus_io.eng_dct_5;
  assign dct_in[6] = bus_io.eng_dct_6;
  assign dct_in[7] = bus_io.eng_dct_7;

  // The engine latches its pixels during LOAD, so the buffer refills from RUN onwards.
  assign in_ready  = (in_cnt_q < 4'd8) && (state_q != StLoad);
  assign in_acc    = bus_io.in_valid && in_ready;
  assign out_valid = (state_q == StDrain);

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_idx_d = out_idx_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    blocks_d  = blocks_q;
    capture   = 1'b0;

    if (in_acc) begin
      in_cnt_d = in_cnt_q + 4'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (in_cnt_q == 4'd8) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        in_cnt_d = 4'd0;
        wd_d     = '0;
        state_d  = StRun;
      end
      StRun: begin
        // eng_done stays high until the next load, so it is only trusted here.
        if (bus_io.eng_done) begin
          capture   = 1'b1;
          out_idx_d = 3'd0;
          state_d   = StDrain;
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StDrain: begin
        if (bus_io.out_ready) begin
          out_idx_d = out_idx_q + 3'd1;
          if (out_idx_q == 3'd7) begin
            blocks_d = blocks_q + CNT_W'(1);
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    eng_start_d = (state_d == StLoad);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      in_cnt_q    <= '0;
      out_idx_q   <= '0;
      wd_q        <= '0;
      eng_start_q <= 1'b0;
      timeout_q   <= 1'b0;
      blocks_q    <= '0;
      for (int i = 0; i < 8; i++) begin
        pix_q[i]  <= '0;
        obuf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_idx_q   <= out_idx_d;
      wd_q        <= wd_d;
      eng_start_q <= eng_start_d;
      timeout_q   <= timeout_d;
      blocks_q    <= blocks_d;
      if (in_acc) begin
        pix_q[in_cnt_q[2:0]] <= bus_io.in_row;
      end
      if (capture) begin
        for (int i = 0; i < 8; i++) begin
          obuf_q[i] <= dct_in[i];
        end
      end
    end
  end

  assign bus_io.in_ready     = in_ready;
  assign bus_io.eng_start    = eng_start_q;
  assign bus_io.out_valid    = out_valid;
  assign bus_io.out_row      = out_valid ? obuf_q[out_idx_q] : '0;
  assign bus_io.out_last     = out_valid && (out_idx_q == 3'd7);
  assign bus_io.busy         = (state_q != StIdle) || (in_cnt_q != 4'd0);
  assign bus_io.timeout_err  = timeout_q;
  assign bus_io.blocks_done  = blocks_q;
  assign bus_io.eng_pixels_0 = pix_q[0];
  assign bus_io.eng_pixels_1 = pix_q[1];
  assign bus_io.eng_pixels_2 = pix_q[2];
  assign bus_io.eng_pixels_3 = pix_q[3];
  assign bus_io.eng_pixels_4 = pix_q[4];
  assign bus_io.eng_pixels_5 = pix_q[5];
  assign bus_io.eng_pixels_6 = pix_q[6];
  assign bus_io.eng_pixels_7 = pix_q[7];

endmodule

// File: tb/tb_dct_block_sequencer.sv
// Bench for dct_block_sequencer: stand-in DCT engine, block-level scoreboard,
// scenario table plus a hand-written reset-mid-drain sequence.
module tb_dct_block_sequencer;

  localparam int unsigned CntW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dct_block_sequencer_if #(.CNT_W(CntW)) bus ();

  dct_block_sequencer #(.TIMEOUT(32), .CNT_W(CntW)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus_io(bus)
  );

  // Stand-in engine: fixed integer transform, result valid only once Done rises.
  function automatic logic [95:0] coef_row(input logic [511:0] blk, input int r);
    logic [95:0] v;
    int acc;
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int c = 0; c < 8; c++) begin
        acc += int'(blk[64*r + 8*c +: 8]) * (c + k + 1) - int'(blk[64*c + 8*k +: 8]) * (r + 1);
      end
      v[12*k +: 12] = acc[11:0];
    end
    return v;
  endfunction

  int          eng_lat = 4;
  logic [7:0]  kill_mask = 8'h00;
  int          eng_starts;
  int          cd;
  logic [511:0] eng_blk;
  logic [95:0] dct_r [8];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.eng_done <= 1'b0;
      cd           <= 0;
      eng_starts   <= 0;
      eng_blk      <= '0;
      for (int r = 0; r < 8; r++) dct_r[r] <= '0;
    end else if (bus.eng_start) begin
      eng_blk <= {bus.eng_pixels_7, bus.eng_pixels_6, bus.eng_pixels_5, bus.eng_pixels_4,
                  bus.eng_pixels_3, bus.eng_pixels_2, bus.eng_pixels_1, bus.eng_pixels_0};
      bus.eng_done <= 1'b0;
      cd           <= eng_lat;
      eng_starts   <= eng_starts + 1;
    end else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1 && !kill_mask[eng_starts-1]) begin
        bus.eng_done <= 1'b1;
        for (int r = 0; r < 8; r++) dct_r[r] <= coef_row(eng_blk, r);
      end else begin
        for (int r = 0; r < 8; r++) dct_r[r] <= {$urandom, $urandom, $urandom};
      end
    end
  end

  assign bus.eng_dct_0 = dct_r[0];
  assign bus.eng_dct_1 = dct_r[1];
  assign bus.eng_dct_2 = dct_r[2];
  assign bus.eng_dct_3 = dct_r[3];
  assign bus.eng_dct_4 = dct_r[4];
  assign bus.eng_dct_5 = dct_r[5];
  assign bus.eng_dct_6 = dct_r[6];
  assign bus.eng_dct_7 = dct_r[7];

  typedef struct {
    int         nblk;
    int         lat;         // 0: random latency per block
    logic [7:0] kill;        // block i never gets Done
    int         rdy;         // 0 always, 1 pattern 1,0,0, 2 random
    int         val;         // 0 continuous, 1 random gaps
    bit         ramp;        // first block uses byte k of row r = 8r+k
    bit         ovl;
    int         exp_blocks;  // final blocks_done (wraps at 4)
    bit         exp_to;
  } scen_t;

  scen_t tbl [7];

  int nvec = 0;
  int nerr = 0;

  // Reference model: block-level view of the buffer, engine and drain.
  int           mcnt, wd, pos, fed, mblocks, loads, rdy_ph, drv_row, nblk_tot;
  bit           core_busy, due, mto, armed, stall_v, stall_last, ovl_chk, rand_lat;
  int           rdy_mode, val_mode;
  logic [95:0]  stall_row;
  logic [63:0]  rows [8];
  logic [511:0] pend [$];
  logic [95:0]  expq [$];
  logic [511:0] drv_blk [$];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_rst(input string nm);
    chk({nm, " in_ready"}, bus.in_ready, 1);
    chk({nm, " eng_start"}, bus.eng_start, 0);
    chk({nm, " out_valid"}, bus.out_valid, 0);
    chk({nm, " out_last"}, bus.out_last, 0);
    chk({nm, " out_row"}, bus.out_row, 0);
    chk({nm, " eng_pixels"}, {bus.eng_pixels_7, bus.eng_pixels_6, bus.eng_pixels_5,
        bus.eng_pixels_4, bus.eng_pixels_3, bus.eng_pixels_2, bus.eng_pixels_1,
        bus.eng_pixels_0}, 0);
    chk({nm, " busy"}, bus.busy, 0);
    chk({nm, " timeout_err"}, bus.timeout_err, 0);
    chk({nm, " blocks_done"}, bus.blocks_done, 0);
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_rst(nm);
    mcnt = 0; wd = 0; pos = 0; fed = 0; mblocks = 0; loads = 0; rdy_ph = 0; drv_row = 0;
    core_busy = 0; due = 0; mto = 0; armed = 0; stall_v = 0;
    pend.delete();
    expq.delete();
    drv_blk.delete();
    rst = 1'b0;
  endtask

  task automatic step();
    bit           es;
    logic [511:0] blk;
    @(negedge clk);
    if (drv_blk.size() > 0 && (val_mode == 0 || $urandom_range(3) != 0)) begin
      blk = drv_blk[0];
      bus.in_valid = 1'b1;
      bus.in_row   = blk[64*drv_row +: 64];
    end else begin
      bus.in_valid = 1'b0;
      bus.in_row   = {$urandom, $urandom};
    end
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = (rdy_ph % 3 == 0);
      default: bus.out_ready = 1'($urandom_range(1));
    endcase
    if (bus.out_valid) rdy_ph++;

    if (armed) begin
      wd++;
      if (wd == 33) begin
        mto = 1; core_busy = 0; armed = 0;
      end
    end
    es  = due;
    due = 0;
    if (mcnt == 8 && !core_busy) begin
      due = 1; core_busy = 1;
    end

    chk("eng_start", bus.eng_start, es);
    chk("in_ready", bus.in_ready, (mcnt < 8) && !es);
    chk("busy", bus.busy, core_busy || (mcnt != 0));
    chk("timeout_err", bus.timeout_err, mto);
    chk("blocks_done", bus.blocks_done, mblocks % 4);

    if (es) begin
      if (pend.size() == 0) begin
        chk("load_without_block", bus.eng_start, 0);
      end else begin
        blk = pend.pop_front();
        chk("eng_pixels", {bus.eng_pixels_7, bus.eng_pixels_6, bus.eng_pixels_5,
            bus.eng_pixels_4, bus.eng_pixels_3, bus.eng_pixels_2, bus.eng_pixels_1,
            bus.eng_pixels_0}, blk);
        if (kill_mask[loads]) begin
          armed = 1; wd = 0;
        end else begin
          for (int r = 0; r < 8; r++) expq.push_back(coef_row(blk, r));
        end
      end
      if (rand_lat) eng_lat = $urandom_range(1, 12);
      loads++;
      mcnt = 0;
    end

    if (bus.in_valid && bus.in_ready && mcnt < 8) begin
      rows[mcnt] = bus.in_row;
      mcnt++;
      drv_row++;
      if (drv_row == 8) begin
        void'(drv_blk.pop_front());
        drv_row = 0;
      end
      if (mcnt == 8) begin
        for (int r = 0; r < 8; r++) blk[64*r +: 64] = rows[r];
        pend.push_back(blk);
        fed++;
      end
    end

    if (stall_v) begin
      chk("stall_hold", {bus.out_valid, bus.out_last, bus.out_row},
          {1'b1, stall_last, stall_row});
    end
    stall_v = 0;
    if (bus.out_valid) begin
      if (expq.size() == 0) begin
        chk("spurious_out_valid", bus.out_valid, 0);
      end else begin
        chk("out_row", bus.out_row, expq[0]);
        chk("out_last", bus.out_last, pos == 7);
        if (bus.out_ready) begin
          void'(expq.pop_front());
          if (ovl_chk && pos == 7 && mblocks + 1 < nblk_tot) begin
            chk("overlap_buffered", fed >= mblocks + 2, 1);
          end
          pos++;
          if (pos == 8) begin
            pos = 0; mblocks++; core_busy = 0;
          end
        end else begin
          stall_v = 1; stall_row = bus.out_row; stall_last = bus.out_last;
        end
      end
    end
  endtask

  task automatic load_scen(input scen_t s);
    logic [511:0] b;
    kill_mask = s.kill;
    rand_lat  = (s.lat == 0);
    eng_lat   = rand_lat ? 4 : s.lat;
    rdy_mode  = s.rdy;
    val_mode  = s.val;
    ovl_chk   = s.ovl;
    nblk_tot  = s.nblk;
    for (int i = 0; i < s.nblk; i++) begin
      for (int r = 0; r < 8; r++) begin
        for (int k = 0; k < 8; k++) begin
          b[64*r + 8*k +: 8] = (s.ramp && i == 0) ? 8'(8*r + k) : 8'($urandom);
        end
      end
      drv_blk.push_back(b);
    end
  endtask

  task automatic run_scen(input int idx);
    int n;
    do_reset($sformatf("reset%0d", idx));
    load_scen(tbl[idx]);
    n = 0;
    while ((drv_blk.size() != 0 || pend.size() != 0 || expq.size() != 0 || core_busy
            || mcnt != 0) && n < 3000) begin
      step();
      n++;
    end
    chk($sformatf("scen%0d_finished", idx), n < 3000, 1);
    step();
    chk($sformatf("scen%0d_final_blocks", idx), bus.blocks_done, tbl[idx].exp_blocks);
    chk($sformatf("scen%0d_final_timeout", idx), bus.timeout_err, tbl[idx].exp_to);
    chk($sformatf("scen%0d_idle", idx), bus.busy, 0);
  endtask

  initial begin
    tbl[0] = '{1, 4,  8'h00, 0, 0, 1'b1, 1'b0, 1, 1'b0};
    tbl[1] = '{1, 4,  8'h00, 1, 0, 1'b0, 1'b0, 1, 1'b0};
    tbl[2] = '{3, 4,  8'h00, 0, 0, 1'b0, 1'b1, 3, 1'b0};
    tbl[3] = '{2, 4,  8'h01, 0, 0, 1'b0, 1'b0, 1, 1'b1};
    tbl[4] = '{5, 0,  8'h00, 2, 1, 1'b0, 1'b0, 1, 1'b0};
    tbl[5] = '{4, 20, 8'h00, 1, 1, 1'b0, 1'b0, 0, 1'b0};
    tbl[6] = '{2, 0,  8'h02, 2, 1, 1'b0, 1'b0, 1, 1'b1};

    for (int i = 0; i < 7; i++) run_scen(i);

    // Reset asserted mid-drain, after three rows have gone out.
    begin
      int n;
      do_reset("reset_pre_drain");
      load_scen(tbl[1]);
      rdy_mode = 0;
      n = 0;
      while (pos < 3 && n < 500) begin
        step();
        n++;
      end
      chk("mid_drain_reached", n < 500, 1);
      @(posedge clk);
      #2;
      chk("pre_reset_out_valid", bus.out_valid, 1);
      rst = 1'b1;
      #1;
      check_rst("mid_drain");
    end
    run_scen(0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
